// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// States, ALU ops, opcode/funct values and mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_I   = 3'd1,
    CL_LW  = 3'd2,
    CL_SW  = 3'd3,
    CL_BR  = 3'd4,
    CL_J   = 3'd5,
    CL_BAD = 3'd6
  } ins_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] PCSRC_ALU = 2'd0;
  localparam logic [1:0] PCSRC_JMP = 2'd1;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to class,
// execute-stage ALU op, B-operand select and funct legality.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ins_class_e cls_o,
  output alu_op_e    alu_op_o,
  output logic [1:0] srcb_o,
  output logic       funct_ok_o
);

  // Classify opcode; R-type ALU op comes from funct
  always_comb begin
    cls_o      = CL_BAD;
    alu_op_o   = ALU_ADD;
    srcb_o     = SRCB_B;
    funct_ok_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        cls_o      = CL_R;
        funct_ok_o = 1'b1;
        unique case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: funct_ok_o = 1'b0;
        endcase
      end
      OP_ADDI: begin
        cls_o  = CL_I;
        srcb_o = SRCB_SEXT;
      end
      OP_ANDI: begin
        cls_o    = CL_I;
        srcb_o   = SRCB_ZEXT;
        alu_op_o = ALU_AND;
      end
      OP_ORI: begin
        cls_o    = CL_I;
        srcb_o   = SRCB_ZEXT;
        alu_op_o = ALU_OR;
      end
      OP_LW: begin
        cls_o  = CL_LW;
        srcb_o = SRCB_SEXT;
      end
      OP_SW: begin
        cls_o  = CL_SW;
        srcb_o = SRCB_SEXT;
      end
      OP_BEQ, OP_BNE: cls_o = CL_BR;
      OP_J:           cls_o = CL_J;
      default:        cls_o = CL_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences each instruction and
// drives every datapath load strobe and mux select.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_write,
  output logic             a_write,
  output logic             b_write,
  output logic             aluout_write,
  output logic             pc_write,
  output logic             pc_inc,
  output logic             reg_write,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_e     state_q, state_d;
  logic       br_ph_q, br_ph_d;
  logic       flag_q, flag_d;
  logic       illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q;

  ins_class_e dec_cls;
  alu_op_e    dec_op;
  logic [1:0] dec_srcb;
  logic       dec_fok;

  mc_decode u_dec (
    .opcode_i   (opcode),
    .funct_i    (funct),
    .cls_o      (dec_cls),
    .alu_op_o   (dec_op),
    .srcb_o     (dec_srcb),
    .funct_ok_o (dec_fok)
  );

  // Next state and all control outputs; everything is 0 in reset
  always_comb begin
    state_d      = state_q;
    br_ph_d      = br_ph_q;
    flag_d       = flag_q;
    ir_write     = 1'b0;
    a_write      = 1'b0;
    b_write      = 1'b0;
    aluout_write = 1'b0;
    pc_write     = 1'b0;
    pc_inc       = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_ADD;
    pc_src       = PCSRC_ALU;
    retire       = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          if (run) begin
            ir_write = 1'b1;
            pc_inc   = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          // aluout captures pc+imm here as the branch target
          a_write      = 1'b1;
          b_write      = 1'b1;
          aluout_write = 1'b1;
          alu_src_b    = SRCB_SEXT;
          br_ph_d      = 1'b0;
          unique case (dec_cls)
            CL_R:         state_d = EXEC_R;
            CL_I:         state_d = EXEC_I;
            CL_LW, CL_SW: state_d = MEM_ADDR;
            CL_BR:        state_d = BRANCH;
            CL_J:         state_d = JUMP;
            default:      state_d = TRAP;
          endcase
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_op    = dec_op;
          if (dec_fok) begin
            aluout_write = 1'b1;
            state_d      = WB_R;
          end else begin
            state_d = TRAP;
          end
        end
        EXEC_I: begin
          alu_src_a    = 1'b1;
          alu_src_b    = dec_srcb;
          alu_op       = dec_op;
          aluout_write = 1'b1;
          state_d      = WB_I;
        end
        MEM_ADDR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = SRCB_SEXT;
          aluout_write = 1'b1;
          state_d = (dec_cls == CL_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: state_d = WB_MEM;
        MEM_WR: begin
          mem_write = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        WB_R: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        WB_I: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        WB_MEM: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          // Phase 0 compares A-B without touching aluout (holds target)
          if (!br_ph_q) begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = ALU_SUB;
            flag_d    = zero;
            br_ph_d   = 1'b1;
          end else begin
            alu_src_b = SRCB_SEXT;
            pc_src    = PCSRC_ALU;
            pc_write  = (opcode == OP_BEQ) ? flag_q : ~flag_q;
            retire    = 1'b1;
            br_ph_d   = 1'b0;
            state_d   = FETCH;
          end
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JMP;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        TRAP:    state_d = TRAP;
        default: state_d = FETCH;
      endcase
    end
    illegal_d = illegal_q | (state_d == TRAP);
  end

  // State, branch sub-phase, latched zero and sticky trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      br_ph_q   <= 1'b0;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_ph_q   <= br_ph_d;
      flag_q    <= flag_d;
      illegal_q <= illegal_d;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule
